// File: rtl/riscv_pkg.sv
// Shared RV32I memory-access encodings and LSU state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane/strobe generation and load byte/half extract with extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [15:0] ld_shift;

  always_comb begin
    st_wdata_o = '0;
    st_wstrb_o = '0;
    case (st_funct3_i)
      F3_B: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_off_i;
      end
      F3_H: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wstrb_o = 4'b0011 << st_off_i;
      end
      F3_W: begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'b1111;
      end
      default: ;
    endcase
  end

  // Bring the addressed byte/half down to bit 0 before extending.
  assign ld_shift = 16'(ld_rdata_i >> {ld_off_i, 3'b000});

  always_comb begin
    ld_data_o = '0;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_data_o = {{16{ld_shift[15]}}, ld_shift};
      F3_W:    ld_data_o = ld_rdata_i;
      F3_BU:   ld_data_o = {24'd0, ld_shift[7:0]};
      F3_HU:   ld_data_o = {16'd0, ld_shift};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one bus request per memory op, stalls the pipe until done.
// Faults (misaligned/illegal) are reported combinationally in IDLE; timeouts in DONE.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        lsu_stall,
  output logic        lsu_load_valid,
  output logic [31:0] lsu_load_data,
  output logic        lsu_fault
);

  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  lsu_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [2:0]           f3_q, f3_d;
  logic [1:0]           off_q, off_d;
  logic [31:0]          data_q, data_d;
  logic                 timeout_q, timeout_d;

  logic        access, is_load, illegal, misaligned, req_fault, issue;
  logic [31:0] st_wdata, ld_ext;
  logic [3:0]  st_wstrb;

  assign access     = mem_MemRead | mem_MemWrite;
  assign is_load    = mem_MemRead;
  assign illegal    = is_load ? (mem_funct3 == 3'b011 || mem_funct3[2:1] == 2'b11)
                              : (mem_funct3 > F3_W);
  assign misaligned = (mem_funct3[1:0] == 2'b01 && mem_alu_result[0]) ||
                      (mem_funct3[1:0] == 2'b10 && mem_alu_result[1:0] != 2'b00);
  assign req_fault  = access && (illegal || misaligned);
  assign issue      = access && !(illegal || misaligned);

  lsu_align u_align (
    .st_funct3_i (mem_funct3),
    .st_off_i    (mem_alu_result[1:0]),
    .st_data_i   (mem_write_data),
    .st_wdata_o  (st_wdata),
    .st_wstrb_o  (st_wstrb),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (dmem_rsp_rdata),
    .ld_data_o   (ld_ext)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    f3_d      = f3_q;
    off_d     = off_q;
    data_d    = data_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d   = REQ;
          we_d      = !is_load;
          addr_d    = {mem_alu_result[31:2], 2'b00};
          wdata_d   = is_load ? 32'd0 : st_wdata;
          wstrb_d   = is_load ? 4'd0 : st_wstrb;
          f3_d      = mem_funct3;
          off_d     = mem_alu_result[1:0];
          timeout_d = 1'b0;
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          state_d = we_q ? DONE : WAIT_RSP;
          cnt_d   = '0;
        end
      end
      WAIT_RSP: begin
        // A response arriving on the last allowed cycle still wins over the timeout.
        if (dmem_rsp_valid) begin
          data_d  = ld_ext;
          state_d = DONE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          data_d    = 32'd0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        timeout_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      data_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
    end
  end

  assign dmem_req_valid = (state_q == REQ);
  assign dmem_req_we    = we_q;
  assign dmem_req_addr  = addr_q;
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_wstrb = wstrb_q;
  assign lsu_stall      = (state_q == IDLE && issue) || state_q == REQ || state_q == WAIT_RSP;
  assign lsu_load_valid = (state_q == DONE) && !we_q;
  assign lsu_load_data  = data_q;
  assign lsu_fault      = (state_q == IDLE && req_fault) || (state_q == DONE && timeout_q);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed, table-driven bench for mem_stage_lsu plus hand sequences for backpressure, timeout and reset.
module tb_mem_stage_lsu;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_MemRead = 1'b0, mem_MemWrite = 1'b0;
  logic [2:0]  mem_funct3 = '0;
  logic [31:0] mem_alu_result = '0, mem_write_data = '0;
  logic        dmem_req_valid, dmem_req_we;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_rdata = '0;
  logic        lsu_stall, lsu_load_valid, lsu_fault;
  logic [31:0] lsu_load_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .lsu_stall(lsu_stall), .lsu_load_valid(lsu_load_valid), .lsu_load_data(lsu_load_data),
    .lsu_fault(lsu_fault)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    int          waits;
    logic        fault;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_data;
  } vec_t;

  vec_t vec[17];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                              input int waits, input logic fault, input logic [31:0] e_addr,
                              input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                              input logic [31:0] e_data);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
    v.waits = waits; v.fault = fault; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_wstrb = e_wstrb; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0; dmem_rsp_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    logic st;
    st = v.wr && !v.rd;
    @(posedge clk); #1;
    mem_MemRead = v.rd; mem_MemWrite = v.wr; mem_funct3 = v.f3;
    mem_alu_result = v.addr; mem_write_data = v.wd; dmem_rsp_rdata = v.rdata;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("idle_fault", 32'(lsu_fault), 32'(v.fault));
    chk("idle_stall", 32'(lsu_stall), 32'(!v.fault));
    chk("idle_req_valid", 32'(dmem_req_valid), 0);
    if (!v.fault) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("req_valid", 32'(dmem_req_valid), 1);
      chk("req_stall", 32'(lsu_stall), 1);
      chk("req_addr", dmem_req_addr, v.e_addr);
      chk("req_we", 32'(dmem_req_we), 32'(st));
      chk("req_wstrb", 32'(dmem_req_wstrb), 32'(v.e_wstrb));
      if (st) chk("req_wdata", dmem_req_wdata, v.e_wdata);
      @(posedge clk); #1;
      if (!st) begin
        for (int i = 0; i < v.waits; i++) begin
          @(negedge clk);
          chk("wait_stall", 32'(lsu_stall), 1);
          chk("wait_load_valid", 32'(lsu_load_valid), 0);
          @(posedge clk); #1;
        end
        dmem_rsp_valid = 1'b1;
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
      end
      @(negedge clk);
      chk("done_stall", 32'(lsu_stall), 0);
      chk("done_load_valid", 32'(lsu_load_valid), 32'(!st));
      chk("done_fault", 32'(lsu_fault), 0);
      if (!st) chk("done_load_data", lsu_load_data, v.e_data);
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("post_req_valid", 32'(dmem_req_valid), 0);
    chk("post_fault", 32'(lsu_fault), 0);
  endtask

  initial begin
    vec[0]  = mk(0, 1, F3_B,  32'h1003, 32'h000000A5, 0, 0, 0, 32'h1000, 32'hA5A5A5A5, 4'b1000, 0);
    vec[1]  = mk(0, 1, F3_H,  32'h4002, 32'h1234BEEF, 0, 0, 0, 32'h4000, 32'hBEEFBEEF, 4'b1100, 0);
    vec[2]  = mk(0, 1, F3_W,  32'h5000, 32'hDEADBEEF, 0, 0, 0, 32'h5000, 32'hDEADBEEF, 4'b1111, 0);
    vec[3]  = mk(0, 1, F3_B,  32'h6000, 32'h12345677, 0, 0, 0, 32'h6000, 32'h77777777, 4'b0001, 0);
    vec[4]  = mk(0, 1, F3_H,  32'h6000, 32'hAAAA5A5A, 0, 0, 0, 32'h6000, 32'h5A5A5A5A, 4'b0011, 0);
    vec[5]  = mk(1, 0, F3_B,  32'h2001, 0, 32'h000080FF, 3, 0, 32'h2000, 0, 4'b0000, 32'hFFFFFF80);
    vec[6]  = mk(1, 0, F3_BU, 32'h2001, 0, 32'h000080FF, 3, 0, 32'h2000, 0, 4'b0000, 32'h00000080);
    vec[7]  = mk(1, 0, F3_H,  32'h2002, 0, 32'h80011234, 1, 0, 32'h2000, 0, 4'b0000, 32'hFFFF8001);
    vec[8]  = mk(1, 0, F3_HU, 32'h2000, 0, 32'h80019234, 0, 0, 32'h2000, 0, 4'b0000, 32'h00009234);
    vec[9]  = mk(1, 0, F3_B,  32'h2003, 0, 32'h7F000000, 2, 0, 32'h2000, 0, 4'b0000, 32'h0000007F);
    vec[10] = mk(1, 0, F3_W,  32'h2004, 0, 32'hCAFEF00D, 0, 0, 32'h2004, 0, 4'b0000, 32'hCAFEF00D);
    vec[11] = mk(1, 0, F3_W,  32'h3002, 0, 0, 0, 1, 0, 0, 4'b0000, 0);
    vec[12] = mk(1, 0, F3_H,  32'h3001, 0, 0, 0, 1, 0, 0, 4'b0000, 0);
    vec[13] = mk(1, 0, 3'b011, 32'h3000, 0, 0, 0, 1, 0, 0, 4'b0000, 0);
    vec[14] = mk(0, 1, 3'b100, 32'h3000, 0, 0, 0, 1, 0, 0, 4'b0000, 0);
    vec[15] = mk(0, 1, F3_H,  32'h3003, 0, 0, 0, 1, 0, 0, 4'b0000, 0);
    vec[16] = mk(1, 1, F3_W,  32'h7000, 32'hFFFFFFFF, 32'h11223344, 1, 0, 32'h7000, 0, 4'b0000, 32'h11223344);

    // Reset values
    #12;
    chk("rst_req_valid", 32'(dmem_req_valid), 0);
    chk("rst_req_we", 32'(dmem_req_we), 0);
    chk("rst_req_addr", dmem_req_addr, 0);
    chk("rst_req_wdata", dmem_req_wdata, 0);
    chk("rst_req_wstrb", 32'(dmem_req_wstrb), 0);
    chk("rst_stall", 32'(lsu_stall), 0);
    chk("rst_load_valid", 32'(lsu_load_valid), 0);
    chk("rst_load_data", lsu_load_data, 0);
    chk("rst_fault", 32'(lsu_fault), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int k = 0; k < 17; k++) run_txn(vec[k]);

    // A store leaves the last load result untouched.
    run_txn(vec[2]);
    chk("hold_load_data", lsu_load_data, 32'h11223344);

    // SH with ready held low for 5 cycles, handshake on the 6th.
    @(posedge clk); #1;
    mem_MemRead = 1'b0; mem_MemWrite = 1'b1; mem_funct3 = F3_H;
    mem_alu_result = 32'h4002; mem_write_data = 32'h1234BEEF; dmem_req_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_stall", 32'(lsu_stall), 1);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) dmem_req_ready = 1'b1;
      @(negedge clk);
      chk("bp_req_valid", 32'(dmem_req_valid), 1);
      chk("bp_stall", 32'(lsu_stall), 1);
      chk("bp_addr", dmem_req_addr, 32'h4000);
      chk("bp_wdata", dmem_req_wdata, 32'hBEEFBEEF);
      chk("bp_wstrb", 32'(dmem_req_wstrb), 32'hC);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_done_stall", 32'(lsu_stall), 0);
    chk("bp_done_req_valid", 32'(dmem_req_valid), 0);
    @(posedge clk); #1;
    clear_inputs();

    // Load timeout after 4 WAIT_RSP cycles.
    mem_MemRead = 1'b1; mem_funct3 = F3_W; mem_alu_result = 32'h8000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_wait_stall", 32'(lsu_stall), 1);
      chk("to_wait_fault", 32'(lsu_fault), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_done_fault", 32'(lsu_fault), 1);
    chk("to_done_load_valid", 32'(lsu_load_valid), 1);
    chk("to_done_data", lsu_load_data, 0);
    chk("to_done_stall", 32'(lsu_stall), 0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("to_post_fault", 32'(lsu_fault), 0);
    chk("to_post_load_valid", 32'(lsu_load_valid), 0);

    // Reset asserted while waiting for a load response.
    @(posedge clk); #1;
    mem_MemRead = 1'b1; mem_funct3 = F3_W; mem_alu_result = 32'h9000; dmem_rsp_rdata = 32'h55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_wait_stall", 32'(lsu_stall), 1);
    #2;
    reset_n = 1'b0;
    clear_inputs();
    #1;
    chk("rw_req_valid", 32'(dmem_req_valid), 0);
    chk("rw_stall", 32'(lsu_stall), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    @(negedge clk);
    chk("rw_late_load_valid", 32'(lsu_load_valid), 0);
    chk("rw_late_req_valid", 32'(dmem_req_valid), 0);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("rw_late_load_valid2", 32'(lsu_load_valid), 0);
    chk("rw_late_data", lsu_load_data, 0);
    run_txn(vec[10]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
